button_conditioner: RTL and testbench

Parametrised multi-channel push-button front end for the game board: synchronises, debounces and edge-shapes `NUM_BTN` active-low button inputs. Each accepted press produces exactly one single-cycle high pulse on `btn_pulse`, plus a debounced level on `btn_held`. It sits between the board pins and the game control FSM, replacing per-button single-flop shapers.

---
 rtl/button_conditioner.sv | 161 ++++++++++++++++
 tb/tb_button_conditioner.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: two-flop synchroniser, per-channel debounce FSM,
// single-cycle press pulses and a debounced held level. Optional auto-repeat via BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int NUM_BTN       = 4,
    parameter int DB_CNT        = 16,
    parameter int CNT_W         = 16,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_held,
    output logic               any_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NUM_BTN-1:0] s0;
    logic [NUM_BTN-1:0] s1;

    // Both stages reset to the released level so a held button after reset counts as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0 <= '1;
            s1 <= '1;
        end else begin
            s0 <= btn_n;
            s1 <= s0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |btn_pulse;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             pulse;
        logic             pulse_next;
        logic             rep_fire;
        logic             s;

        assign s            = s1[g];
        assign btn_pulse[g] = pulse;
        assign btn_held[g]  = (state == HELD);

        always_ff @(posedge clk) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
                pulse <= pulse_next | rep_fire;
            end
        end

        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            pulse_next = 1'b0;
            unique case (state)
                IDLE: begin
                    if (!s) begin
                        if (DB_CNT == 1) begin
                            state_next = HELD;
                            cnt_next   = '0;
                            pulse_next = 1'b1;
                        end else begin
                            state_next = PRESS_WAIT;
                            cnt_next   = ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt + ONE == DB_LAST) begin
                        state_next = HELD;
                        cnt_next   = '0;
                        pulse_next = 1'b1;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
                HELD: begin
                    // Any low sample while held restarts the release count (bounce rejection).
                    if (s) begin
                        if (cnt + ONE == DB_LAST) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + ONE;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [CNT_W-1:0] rcnt;
        logic [CNT_W-1:0] rcnt_next;
        logic             rep_phase;
        logic             rep_phase_next;

        always_ff @(posedge clk) begin
            if (!rst) begin
                rcnt      <= '0;
                rep_phase <= 1'b0;
            end else begin
                rcnt      <= rcnt_next;
                rep_phase <= rep_phase_next;
            end
        end

        // rep_phase selects the first-repeat delay versus the steady repeat period.
        always_comb begin
            rcnt_next      = rcnt + ONE;
            rep_phase_next = rep_phase;
            rep_fire       = 1'b0;
            if (state != HELD || s) begin
                rcnt_next      = '0;
                rep_phase_next = 1'b0;
            end else if (rcnt + ONE == (rep_phase ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY))) begin
                rcnt_next      = '0;
                rep_phase_next = 1'b1;
                rep_fire       = 1'b1;
            end
        end
`else
        logic [CNT_W-1:0] unused_repeat;
        assign unused_repeat = CNT_W'(REPEAT_DELAY) ^ CNT_W'(REPEAT_PERIOD);
        assign rep_fire      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse cycles are queued when stimulus is
// driven and popped as the DUT is sampled on each falling edge.
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] btn_n = '1;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_held;
    logic          any_pulse;

    int vec = 0;
    int err = 0;
    int cyc = 0;

    typedef struct {
        int            cyc;
        logic [NB-1:0] mask;
    } exp_t;

    exp_t pulse_q[$];
    int   any_q[$];

    button_conditioner #(
        .NUM_BTN(NB),
        .DB_CNT(DB),
        .CNT_W(16),
        .REPEAT_DELAY(1000),
        .REPEAT_PERIOD(250)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n(btn_n),
        .btn_pulse(btn_pulse),
        .btn_held(btn_held),
        .any_pulse(any_pulse)
    );

`ifdef BTN_AUTOREPEAT_EN
    logic [NB-1:0] rep_btn_n = '1;
    logic [NB-1:0] rep_pulse;
    logic [NB-1:0] rep_held;
    logic          rep_any;

    button_conditioner #(
        .NUM_BTN(NB),
        .DB_CNT(2),
        .CNT_W(16),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut_rep (
        .clk(clk),
        .rst(rst),
        .btn_n(rep_btn_n),
        .btn_pulse(rep_pulse),
        .btn_held(rep_held),
        .any_pulse(rep_any)
    );
`endif

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen; outputs are sampled on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NB-1:0] pop_pulse(int c);
        pop_pulse = '0;
        if (pulse_q.size() != 0 && pulse_q[0].cyc == c) begin
            pop_pulse = pulse_q[0].mask;
            pulse_q.delete(0);
        end
    endfunction

    function automatic logic pop_any(int c);
        pop_any = 1'b0;
        if (any_q.size() != 0 && any_q[0] == c) begin
            pop_any = 1'b1;
            any_q.delete(0);
        end
    endfunction

    function automatic void push_press(int c, logic [NB-1:0] mask);
        pulse_q.push_back('{c, mask});
        any_q.push_back(c + 1);
    endfunction

    task automatic test_reset();
        rst   = 1'b0;
        btn_n = '1;
        repeat (3) @(negedge clk);
        vec++;
        if (btn_pulse !== '0 || btn_held !== '0 || any_pulse !== 1'b0) begin
            err++;
            $display("[TB] FAIL reset: pulse=%b held=%b any=%b, required 0000/0000/0",
                     btn_pulse, btn_held, any_pulse);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_press();
        int            t0;
        logic [NB-1:0] ep;
        logic [NB-1:0] eh;
        logic          ea;
        t0 = cyc;
        push_press(t0 + DB + 2, 4'b0001);
        for (int i = 0; i < 66; i++) begin
            ep = pop_pulse(cyc);
            ea = pop_any(cyc);
            eh = (cyc >= t0 + DB + 2 && cyc < t0 + 50 + DB + 2) ? 4'b0001 : 4'b0000;
            vec++;
            if (btn_pulse !== ep || btn_held !== eh || any_pulse !== ea) begin
                err++;
                $display("[TB] FAIL single_press cyc+%0d: pulse=%b held=%b any=%b, required %b/%b/%b",
                         cyc - t0, btn_pulse, btn_held, any_pulse, ep, eh, ea);
            end
            if (i == 0) btn_n[0] = 1'b0;
            if (i == 50) btn_n[0] = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 15; i++) begin
            vec++;
            if (btn_pulse !== '0 || btn_held !== '0 || any_pulse !== 1'b0) begin
                err++;
                $display("[TB] FAIL glitch cyc+%0d: pulse=%b held=%b any=%b, required all 0",
                         cyc - t0, btn_pulse, btn_held, any_pulse);
            end
            if (i == 0) btn_n[1] = 1'b0;
            if (i == 2) btn_n[1] = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        int            t0;
        logic [NB-1:0] ep;
        logic [NB-1:0] eh;
        logic          ea;
        t0 = cyc;
        push_press(t0 + DB + 2, 4'b0001);
        for (int i = 0; i < 55; i++) begin
            ep = pop_pulse(cyc);
            ea = pop_any(cyc);
            eh = (cyc >= t0 + DB + 2 && cyc < t0 + 40 + DB + 2) ? 4'b0001 : 4'b0000;
            vec++;
            if (btn_pulse !== ep || btn_held !== eh || any_pulse !== ea) begin
                err++;
                $display("[TB] FAIL bounce cyc+%0d: pulse=%b held=%b any=%b, required %b/%b/%b",
                         cyc - t0, btn_pulse, btn_held, any_pulse, ep, eh, ea);
            end
            if (i == 0) btn_n[0] = 1'b0;
            if (i == 20) btn_n[0] = 1'b1;
            if (i == 23) btn_n[0] = 1'b0;
            if (i == 40) btn_n[0] = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        int            t0;
        logic [NB-1:0] ep;
        logic [NB-1:0] eh;
        logic          ea;
        t0 = cyc;
        push_press(t0 + DB + 2, 4'b1111);
        for (int i = 0; i < 35; i++) begin
            ep = pop_pulse(cyc);
            ea = pop_any(cyc);
            eh = (cyc >= t0 + DB + 2 && cyc < t0 + 20 + DB + 2) ? 4'b1111 : 4'b0000;
            vec++;
            if (btn_pulse !== ep || btn_held !== eh || any_pulse !== ea) begin
                err++;
                $display("[TB] FAIL simultaneous cyc+%0d: pulse=%b held=%b any=%b, required %b/%b/%b",
                         cyc - t0, btn_pulse, btn_held, any_pulse, ep, eh, ea);
            end
            if (i == 0) btn_n = 4'b0000;
            if (i == 20) btn_n = 4'b1111;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int            t0;
        logic [NB-1:0] ep;
        logic [NB-1:0] eh;
        logic          ea;
        t0 = cyc;
        push_press(t0 + DB + 2, 4'b1000);
        push_press(t0 + 20 + DB + 2, 4'b1000);
        for (int i = 0; i < 45; i++) begin
            ep = pop_pulse(cyc);
            ea = pop_any(cyc);
            eh = ((cyc >= t0 + DB + 2 && cyc < t0 + 12 + DB + 2) ||
                  (cyc >= t0 + 20 + DB + 2 && cyc < t0 + 32 + DB + 2)) ? 4'b1000 : 4'b0000;
            vec++;
            if (btn_pulse !== ep || btn_held !== eh || any_pulse !== ea) begin
                err++;
                $display("[TB] FAIL back_to_back cyc+%0d: pulse=%b held=%b any=%b, required %b/%b/%b",
                         cyc - t0, btn_pulse, btn_held, any_pulse, ep, eh, ea);
            end
            if (i == 0) btn_n[3] = 1'b0;
            if (i == 12) btn_n[3] = 1'b1;
            if (i == 20) btn_n[3] = 1'b0;
            if (i == 32) btn_n[3] = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_held();
        int            t0;
        logic [NB-1:0] ep;
        logic [NB-1:0] eh;
        logic          ea;
        t0 = cyc;
        push_press(t0 + DB + 2, 4'b0100);
        push_press(t0 + 19 + DB + 1, 4'b0100);
        for (int i = 0; i < 50; i++) begin
            ep = pop_pulse(cyc);
            ea = pop_any(cyc);
            eh = ((cyc >= t0 + DB + 2 && cyc < t0 + 16) ||
                  (cyc >= t0 + 19 + DB + 1 && cyc < t0 + 35 + DB + 2)) ? 4'b0100 : 4'b0000;
            vec++;
            if (btn_pulse !== ep || btn_held !== eh || any_pulse !== ea) begin
                err++;
                $display("[TB] FAIL reset_held cyc+%0d: pulse=%b held=%b any=%b, required %b/%b/%b",
                         cyc - t0, btn_pulse, btn_held, any_pulse, ep, eh, ea);
            end
            if (i == 0) btn_n[2] = 1'b0;
            if (i == 15) rst = 1'b0;
            if (i == 18) rst = 1'b1;
            if (i == 35) btn_n[2] = 1'b1;
            @(negedge clk);
        end
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int            t0;
        logic [NB-1:0] ep;
        logic          eh;
        t0 = cyc;
        pulse_q.push_back('{t0 + 4, 4'b0001});
        pulse_q.push_back('{t0 + 14, 4'b0001});
        pulse_q.push_back('{t0 + 19, 4'b0001});
        pulse_q.push_back('{t0 + 24, 4'b0001});
        pulse_q.push_back('{t0 + 29, 4'b0001});
        for (int i = 0; i < 45; i++) begin
            ep = pop_pulse(cyc);
            eh = (cyc >= t0 + 4 && cyc < t0 + 34);
            vec++;
            if (rep_pulse !== ep || rep_held[0] !== eh) begin
                err++;
                $display("[TB] FAIL autorepeat cyc+%0d: pulse=%b held=%b, required %b/%b",
                         cyc - t0, rep_pulse, rep_held[0], ep, eh);
            end
            if (i == 0) rep_btn_n[0] = 1'b0;
            if (i == 30) rep_btn_n[0] = 1'b1;
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_queue_drained();
        vec++;
        if (pulse_q.size() != 0 || any_q.size() != 0) begin
            err++;
            $display("[TB] FAIL queue_drained: pulse_q=%0d any_q=%0d entries left, required 0",
                     pulse_q.size(), any_q.size());
        end
        pulse_q.delete();
        any_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_queue_drained();
        test_glitch();
        test_bounce();
        test_queue_drained();
        test_simultaneous();
        test_queue_drained();
        test_back_to_back();
        test_queue_drained();
        test_reset_held();
        test_queue_drained();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
        test_queue_drained();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
